sync_fifo_top: RTL and testbench
================================

// Module: sync_fifo_top
// PURPOSE
//  Single-clock parametrised FIFO. Successor to the async FIFO for same-domain buffering.
//  Keeps the push/full/wrdata and pop/empty/rddata handshake.
//  Adds programmable almost_full/almost_empty thresholds, an occupancy count and overflow/underflow pulses.
//  Sits between producer/consumer blocks sharing clk; optional first-word-fall-through read mode.
// PARAMETERS
//  DWIDTH    8   data width in bits
//  DEPTH     16  number of entries; power of 2, >= 2
//  AFULL_TH  12  almost_full asserted when count >= AFULL_TH (1..DEPTH)
//  AEMPTY_TH 4   almost_empty asserted when count <= AEMPTY_TH (0..DEPTH-1)
//  (local) AWIDTH = $clog2(DEPTH)
// PORTS
//  clk          in   1         single clock, all logic on posedge
//  reset_L      in   1         synchronous, active-low reset
//  push         in   1         write request
//  wrdata       in   DWIDTH    write data, sampled with accepted push
//  full         out  1         count == DEPTH
//  almost_full  out  1         count >= AFULL_TH
//  overflow     out  1         1-cycle pulse: push rejected previous cycle
//  pop          in   1         read request
//  rddata       out  DWIDTH    read data
//  empty        out  1         count == 0
//  almost_empty out  1         count <= AEMPTY_TH
//  underflow    out  1         1-cycle pulse: pop rejected previous cycle
//  count        out  AWIDTH+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (reset_L low at posedge clk):
//  - wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0.
//  - overflow=0, underflow=0, rddata=0. Storage array not cleared.
//  - Reset mid-operation discards all contents; nothing written before reset is ever read afterwards.
//  Acceptance, evaluated on the registered flags:
//  - pop_ok  = pop & ~empty.
//  - push_ok = push & (~full | pop_ok). A push while full is accepted only if a pop is accepted in the same cycle.
//  - A pop while empty is always rejected, even with a simultaneous push.
//  - Rejected push: no write, pointers unchanged, overflow=1 for exactly the next cycle.
//  - Rejected pop: no pointer move, rddata holds, underflow=1 for exactly the next cycle.
//  Count, flags and pointers:
//  - count_next = count + push_ok - pop_ok.
//  - All flags are registered and computed from count_next, so they are valid the cycle after the edge.
//  - Pointers are AWIDTH bits and wrap DEPTH-1 -> 0 naturally.
//  - Simultaneous push_ok & pop_ok: count unchanged, both pointers advance.
//  Standard read (macro absent):
//  - rddata is registered: mem[rd_ptr] is loaded on the pop_ok edge and is valid the cycle after pop.
//  - rddata holds its value otherwise.
//  - Minimum latency push -> data: push at edge N, empty=0 after N, pop at N+1, rddata valid after N+1.
//  - Throughput: 1 push and 1 pop per cycle sustained.
// CONFIGURATION
//  SYNC_FIFO_FWFT_EN defined (first-word-fall-through):
//  - rddata continuously shows the head entry mem[rd_ptr] whenever empty=0.
//  - pop_ok acknowledges and consumes the current rddata; the next entry appears the following cycle.
//  - A push into an empty FIFO is visible on rddata the cycle after the push edge, when empty falls.
//  - rddata is don't-care while empty=1.
//  - Flags and count behave exactly as in standard mode.
//  SYNC_FIFO_FWFT_EN undefined: standard read, as in BEHAVIOUR.
// TESTING (DEPTH=16, DWIDTH=8, AFULL_TH=12, AEMPTY_TH=4)
//  1 Reset: hold reset_L=0 for 2 clks -> empty=1, almost_empty=1, full=0, count=0, rddata=0x00, overflow=0, underflow=0.
//  2 Fill: push 0x00..0x0F on 16 consecutive cycles
//    -> almost_empty=0 once count=5; almost_full=1 once count=12; full=1 at count=16.
//    -> 17th push: overflow pulse for 1 cycle, count stays 16.
//  3 Drain: pop 16 times -> rddata 0x00..0x0F in order, each the cycle after its pop; empty=1 after the last.
//    -> extra pop: underflow pulse for 1 cycle, rddata holds 0x0F.
//    -> FWFT build: rddata=0x00 with no pop issued; each pop advances rddata.
//  4 Simultaneous push/pop:
//    -> when full: count stays 16, no overflow, data order preserved.
//    -> when empty: push accepted, pop rejected, underflow=1, count=1.
//  5 Wrap: 40 cycles of push+pop at count=1 with data 0x20..0x47 -> output order matches input; pointers wrap twice.
//  6 Reset mid-op: at count=9 drive reset_L=0 for 1 clk -> count=0, empty=1 next cycle.
//    -> then push 0xA5 and pop: rddata=0xA5, no pre-reset data returned.

Source files
------------

// File: rtl/sync_fifo_top.sv
// Purpose : single-clock parametrised FIFO with programmable almost-full/almost-empty thresholds, occupancy count and overflow/underflow pulses.
// Latency : push -> empty=0 one edge later; standard read returns rddata one edge after the accepted pop; FWFT shows the head word as soon as empty=0.
// Backpr. : push is refused while full unless a pop is accepted in the same cycle; pop is refused while empty; refusals raise a one-cycle overflow/underflow pulse.
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (rddata continuously presents the head entry; pop consumes it).
//
// Ports
//   clk          in   1          single clock, all state updates on posedge
//   reset_L      in   1          synchronous active-low reset
//   push         in   1          write request
//   wrdata       in   DWIDTH     write data, captured with an accepted push
//   full         out  1          count == DEPTH
//   almost_full  out  1          count >= AFULL_TH
//   overflow     out  1          one-cycle pulse: a push was refused last cycle
//   pop          in   1          read request
//   rddata       out  DWIDTH     read data
//   empty        out  1          count == 0
//   almost_empty out  1          count <= AEMPTY_TH
//   underflow    out  1          one-cycle pulse: a pop was refused last cycle
//   count        out  AWIDTH+1   current occupancy, 0..DEPTH
//
// Parameters: DEPTH must be a power of two >= 2 so that the AWIDTH-bit
// pointers wrap DEPTH-1 -> 0 with plain binary increment.
// AFULL_TH is meaningful in 1..DEPTH, AEMPTY_TH in 0..DEPTH-1.

module sync_fifo_top #(
    parameter int DWIDTH    = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 4
) (
    input  logic                       clk,
    input  logic                       reset_L,
    input  logic                       push,
    input  logic [DWIDTH-1:0]          wrdata,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       pop,
    output logic [DWIDTH-1:0]          rddata,
    output logic                       empty,
    output logic                       almost_empty,
    output logic                       underflow,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AWIDTH = $clog2(DEPTH);
    localparam int CW     = AWIDTH + 1;

    // Thresholds pre-sized to the count width so comparisons stay width-matched.
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] mem [DEPTH];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;

    logic              full_q,   full_d;
    logic              afull_q,  afull_d;
    logic              empty_q,  empty_d;
    logic              aempty_q, aempty_d;
    logic              ovf_q,    ovf_d;
    logic              udf_q,    udf_d;

    logic              pop_ok;
    logic              push_ok;

    // ------------------------------------------------------------------
    // Acceptance and next state
    // ------------------------------------------------------------------
    // Acceptance looks only at registered flags, so there is no
    // combinational path from push/pop to the flag outputs. A push into a
    // full FIFO is legal only when a pop frees the slot in the same cycle;
    // a pop from an empty FIFO is never rescued by a simultaneous push
    // because the pushed word is not yet in storage.
    always_comb begin
        pop_ok   = pop & ~empty_q;
        push_ok  = push & (~full_q | pop_ok);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AWIDTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AWIDTH'(1);
        end

        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);

        // Flags are derived from the next count and registered, so they
        // describe the occupancy that holds after this edge.
        full_d   = (count_d == DEPTH_C);
        afull_d  = (count_d >= AFULL_C);
        empty_d  = (count_d == '0);
        aempty_d = (count_d <= AEMPTY_C);

        // Pulses last exactly one cycle because they are recomputed every edge.
        ovf_d    = push & ~push_ok;
        udf_d    = pop & ~pop_ok;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // Resetting the pointers together with the count is what guarantees
    // that pre-reset contents are unreachable: the storage itself is left
    // untouched, but every slot must be rewritten before it can be read.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage (no reset)
    // ------------------------------------------------------------------
    // Writes are suppressed during reset so a push held across reset cannot
    // disturb storage; the pointers would make it unreachable anyway.
    always_ff @(posedge clk) begin
        if (reset_L && push_ok) begin
            mem[wr_ptr_q] <= wrdata;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
`ifdef SYNC_FIFO_FWFT_EN
    // First-word-fall-through: the head slot is presented directly. A push
    // into an empty FIFO writes the slot rd_ptr already points at, so it is
    // visible as soon as empty falls. The output is forced to zero while
    // empty so it never exposes stale or pre-reset storage.
    assign rddata = empty_q ? '0 : mem[rd_ptr_q];
`else
    // Standard read: the head word is registered on the accepting edge and
    // held until the next accepted pop. When full with a simultaneous
    // push/pop, wr_ptr == rd_ptr; the non-blocking write means the old head
    // is captured here, preserving order.
    logic [DWIDTH-1:0] rddata_q;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            rddata_q <= '0;
        end else if (pop_ok) begin
            rddata_q <= mem[rd_ptr_q];
        end
    end

    assign rddata = rddata_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign overflow     = ovf_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign underflow    = udf_q;
    assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo_top.sv
// Purpose : directed self-checking bench for sync_fifo_top (DEPTH=16, DWIDTH=8, AFULL_TH=12, AEMPTY_TH=4).
// Latency : read data checked one edge after an accepted pop (standard) or before the popping edge (FWFT).
// Backpr. : stimulus is issued one cycle at a time; read data is checked by an independent scoreboard monitor.

module tb_sync_fifo_top;

    logic       clk;
    logic       reset_L;
    logic       push;
    logic [7:0] wrdata;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       pop;
    logic [7:0] rddata;
    logic       empty;
    logic       almost_empty;
    logic       underflow;
    logic [4:0] count;

    // Set by stimulus when the pop it issues is known to be accepted.
    logic       pop_exp;
    logic       pop_exp_q;

    logic [7:0] exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    sync_fifo_top #(
        .DWIDTH   (8),
        .DEPTH    (16),
        .AFULL_TH (12),
        .AEMPTY_TH(4)
    ) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .push        (push),
        .wrdata      (wrdata),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .pop         (pop),
        .rddata      (rddata),
        .empty       (empty),
        .almost_empty(almost_empty),
        .underflow   (underflow),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; returns #1 after the edge with inputs idle.
    task automatic drive(input logic p, input logic [7:0] d, input logic q,
                         input logic e, input logic [7:0] ed);
        push    = p;
        wrdata  = d;
        pop     = q;
        pop_exp = e;
        if (e) exp_q.push_back(ed);
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        pop_exp = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor
    // ------------------------------------------------------------------
    always @(posedge clk) pop_exp_q <= pop_exp;

    always @(negedge clk) begin
        logic fire;
        logic [7:0] e;
`ifdef SYNC_FIFO_FWFT_EN
        fire = pop_exp;
`else
        fire = pop_exp_q;
`endif
        if (fire === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_underrun", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rddata", {24'd0, rddata}, {24'd0, e});
            end
        end
    end

    // ------------------------------------------------------------------
    // Global watchdog
    // ------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        reset_L   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        wrdata    = '0;
        pop_exp   = 1'b0;
        pop_exp_q = 1'b0;

        // 1: reset held for two clocks
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty",  {31'd0, empty},        32'd1);
        check("rst_aempty", {31'd0, almost_empty}, 32'd1);
        check("rst_full",   {31'd0, full},         32'd0);
        check("rst_afull",  {31'd0, almost_full},  32'd0);
        check("rst_count",  {27'd0, count},        32'd0);
        check("rst_rddata", {24'd0, rddata},       32'd0);
        check("rst_ovf",    {31'd0, overflow},     32'd0);
        check("rst_udf",    {31'd0, underflow},    32'd0);
        reset_L = 1'b1;

        // 2: fill 0x00..0x0F, tracking flag thresholds
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
            check("fill_count",  {27'd0, count},        32'(i + 1));
            check("fill_aempty", {31'd0, almost_empty}, {31'd0, (i + 1) <= 4});
            check("fill_afull",  {31'd0, almost_full},  {31'd0, (i + 1) >= 12});
            check("fill_full",   {31'd0, full},         {31'd0, (i + 1) == 16});
            check("fill_empty",  {31'd0, empty},        32'd0);
        end
        drive(1'b1, 8'hFF, 1'b0, 1'b0, 8'h00);
        check("ovf_pulse", {31'd0, overflow}, 32'd1);
        check("ovf_count", {27'd0, count},    32'd16);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("ovf_clear", {31'd0, overflow}, 32'd0);

        // 3: drain in order
`ifdef SYNC_FIFO_FWFT_EN
        check("fwft_head", {24'd0, rddata}, 32'h00);
`endif
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
            check("drain_count", {27'd0, count}, 32'(15 - i));
        end
        check("drain_empty", {31'd0, empty}, 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        check("udf_pulse", {31'd0, underflow}, 32'd1);
        check("udf_count", {27'd0, count},     32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("udf_hold",  {24'd0, rddata},    32'h0F);
`endif
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        check("udf_clear", {31'd0, underflow}, 32'd0);

        // 4a: simultaneous push/pop while full
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00);
        end
        check("full_again", {31'd0, full}, 32'd1);
        drive(1'b1, 8'h30, 1'b1, 1'b1, 8'h10);
        check("pp_full_count", {27'd0, count},    32'd16);
        check("pp_full_ovf",   {31'd0, overflow}, 32'd0);
        check("pp_full_full",  {31'd0, full},     32'd1);
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h10 + i));
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h30);
        check("pp_full_drained", {31'd0, empty}, 32'd1);

        // 4b: simultaneous push/pop while empty
        drive(1'b1, 8'h55, 1'b1, 1'b0, 8'h00);
        check("pp_empty_udf",   {31'd0, underflow}, 32'd1);
        check("pp_empty_count", {27'd0, count},     32'd1);
        check("pp_empty_ovf",   {31'd0, overflow},  32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h55);
        check("pp_empty_drained", {27'd0, count}, 32'd0);

        // 5: 40 words through at occupancy 1, pointers wrap
        drive(1'b1, 8'h20, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 39; i++) begin
            drive(1'b1, 8'(8'h21 + i), 1'b1, 1'b1, 8'(8'h20 + i));
            check("wrap_count", {27'd0, count}, 32'd1);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h47);
        check("wrap_end_count", {27'd0, count}, 32'd0);

        // 6: reset with 9 entries queued
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 8'h00);
        end
        check("mid_count", {27'd0, count}, 32'd9);
        reset_L = 1'b0;
        @(posedge clk);
        #1;
        reset_L = 1'b1;
        check("mid_rst_count", {27'd0, count}, 32'd0);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        drive(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
        check("post_rst_count", {27'd0, count}, 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5);
        check("post_rst_empty", {31'd0, empty}, 32'd1);

        // Let the monitor retire the last expected word.
        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
